// File: rtl/multi_port_dram.sv
// multi_port_dram: NPORTS-port word memory with zero-fill after reset, write-conflict tracking and range checks
module multi_port_dram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH = 3075,
  parameter int NPORTS = 4,
  parameter int READ_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS*DATA_W-1:0] data_in,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS-1:0]        re,
  output logic [NPORTS*DATA_W-1:0] data_out,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS-1:0]        addr_err,
  output logic                     wr_conflict,
  output logic [15:0]              conflict_cnt,
  output logic                     ready
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [PW-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] din [NPORTS];
  logic [DATA_W-1:0] fwd [NPORTS];
  logic [ADDR_W-1:0] a [NPORTS];
  logic [NPORTS-1:0] ok, wv, rv, hit;
  logic conflict, run;
  assign run = state == RUN;
  assign ready = run;
  // Forwarding keeps the last matching port, so the highest-numbered writer wins like the array update.
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      din[p] = data_in[p*DATA_W +: DATA_W];
      a[p] = addr[p*ADDR_W +: ADDR_W];
      ok[p] = {1'b0, a[p]} < LIM;
      wv[p] = run && we[p] && ok[p];
      rv[p] = run && re[p];
    end
    for (int p = 0; p < NPORTS; p++) begin
      hit[p] = 1'b0;
      fwd[p] = '0;
      for (int q = 0; q < NPORTS; q++) begin
        if (wv[q] && a[q] == a[p]) begin
          hit[p] = 1'b1;
          fwd[p] = din[q];
        end
        if (q < p && wv[q] && wv[p] && a[q] == a[p]) conflict = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!run) mem[ptr] <= '0;
    else
      for (int p = 0; p < NPORTS; p++)
        if (wv[p]) mem[PW'(a[p])] <= din[p];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
      data_out <= '0;
      rvalid <= '0;
      addr_err <= '0;
      wr_conflict <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (!run) begin
        ptr <= ptr == LAST ? '0 : ptr + PW'(1);
        state <= ptr == LAST ? RUN : CLEAR;
      end
      wr_conflict <= conflict;
      if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      rvalid <= rv;
      addr_err <= (we | re) & ~ok & {NPORTS{run}};
      for (int p = 0; p < NPORTS; p++)
        if (rv[p])
          data_out[p*DATA_W +: DATA_W] <= !ok[p] ? '0 :
            (READ_MODE != 0 && hit[p]) ? fwd[p] : mem[PW'(a[p])];
    end
  end
endmodule

// File: tb/tb_multi_port_dram.sv
// tb_multi_port_dram: scoreboard bench driving a read-old and a write-first instance with identical traffic
module tb_multi_port_dram;
  localparam int DW = 32, AW = 12, DEPTH = 3075, NP = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [NP*DW-1:0] data_in, dout0, dout1;
  logic [NP*AW-1:0] addr;
  logic [NP-1:0] we, re, rv0, rv1, ae0, ae1;
  logic wc0, wc1, rdy0, rdy1;
  logic [15:0] cc0, cc1;
  typedef struct {int p; logic [31:0] e0; logic [31:0] e1;} rd_t;
  rd_t rdq[$];
  logic [NP:0] evq[$];
  int total = 0, bad = 0;

  multi_port_dram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NPORTS(NP), .READ_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .we(we), .re(re),
    .data_out(dout0), .rvalid(rv0), .addr_err(ae0), .wr_conflict(wc0),
    .conflict_cnt(cc0), .ready(rdy0));
  multi_port_dram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NPORTS(NP), .READ_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr), .we(we), .re(re),
    .data_out(dout1), .rvalid(rv1), .addr_err(ae1), .wr_conflict(wc1),
    .conflict_cnt(cc1), .ready(rdy1));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    we[p] = 1'b1;
    addr[p*AW +: AW] = AW'(a);
    data_in[p*DW +: DW] = d;
  endtask

  task automatic rd(int p, int a, logic [31:0] e0, logic [31:0] e1);
    rd_t e;
    re[p] = 1'b1;
    addr[p*AW +: AW] = AW'(a);
    e.p = p;
    e.e0 = e0;
    e.e1 = e1;
    rdq.push_back(e);
  endtask

  task automatic cyc(logic [NP-1:0] ae, logic cf);
    evq.push_back({cf, ae});
    @(negedge clk);
    we = '0;
    re = '0;
  endtask

  task automatic wait_ready(int exp);
    int n = 0;
    while (!rdy0 && n < exp + 20) begin
      @(posedge clk);
      #1 n++;
    end
    we = '0;
    re = '0;
    chk("fill_cycles", n, exp);
    chk("ready_wf", rdy1, 1);
  endtask

  task automatic chk_reset();
    chk("rst_ready", {rdy1, rdy0}, 0);
    chk("rst_cnt", {cc1, cc0}, 0);
    chk("rst_rvalid", {rv1, rv0}, 0);
    chk("rst_dout", dout0[31:0] | dout0[127:96] | dout1[63:32], 0);
    chk("rst_err", {wc1, wc0, ae1, ae0}, 0);
  endtask

  initial begin : monitor
    logic [NP:0] ev;
    rd_t e;
    forever begin
      @(posedge clk);
      #1 ev = evq.size() != 0 ? evq.pop_front() : '0;
      chk("addr_err", {ae1, ae0}, {ev[NP-1:0], ev[NP-1:0]});
      chk("wr_conflict", {wc1, wc0}, {ev[NP], ev[NP]});
      for (int p = 0; p < NP; p++)
        if (rv0[p] | rv1[p]) begin
          if (rdq.size() == 0) chk("unexpected_rvalid", p, 32'hFFFF_FFFF);
          else begin
            e = rdq.pop_front();
            chk("rd_port", p, e.p);
            chk("rvalid_pair", {rv1[p], rv0[p]}, 2'b11);
            chk("rd_data_old", dout0[p*DW +: DW], e.e0);
            chk("rd_data_wf", dout1[p*DW +: DW], e.e1);
          end
        end
    end
  end

  initial begin
    we = '0;
    re = '0;
    addr = '0;
    data_in = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    we[0] = 1'b1;
    re[0] = 1'b1;
    data_in = '1;
    rst_n = 1'b1;
    wait_ready(DEPTH);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i += NP) begin
      for (int p = 0; p < NP; p++)
        if (i + p < DEPTH) rd(p, i + p, 0, 0);
      cyc(0, 0);
    end
    wr(1, 5, 32'hDEADBEEF); cyc(0, 0);
    rd(2, 5, 32'hDEADBEEF, 32'hDEADBEEF); cyc(0, 0);
    cyc(0, 0);
    wr(0, 100, 32'h1); wr(3, 100, 32'h3); cyc(0, 1);
    chk("cnt_one", {cc1, cc0}, {16'd1, 16'd1});
    rd(0, 100, 32'h3, 32'h3); cyc(0, 0);
    wr(2, 7, 32'hA); cyc(0, 0);
    wr(0, 7, 32'hB); rd(1, 7, 32'hA, 32'hB); cyc(0, 0);
    rd(3, 7, 32'hB, 32'hB); cyc(0, 0);
    wr(3, 9, 32'h99); rd(3, 9, 32'h0, 32'h99); cyc(0, 0);
    wr(0, 11, 32'h10); rd(1, 11, 32'h0, 32'h12); wr(2, 11, 32'h12); cyc(0, 1);
    rd(0, 11, 32'h12, 32'h12); rd(1, 9, 32'h99, 32'h99); cyc(0, 0);
    wr(2, DEPTH, 32'h55); cyc(4'b0100, 0);
    rd(2, DEPTH, 0, 0); rd(3, DEPTH - 1, 0, 0); cyc(4'b0100, 0);
    wr(1, DEPTH + 7, 32'h77); rd(2, 0, 0, 0); cyc(4'b0010, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("cnt_two", {cc1, cc0}, {16'd2, 16'd2});
    chk("rdq_drained", rdq.size(), 0);
    re[0] = 1'b1;
    addr[0 +: AW] = AW'(5);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    re = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(DEPTH);
    @(negedge clk);
    rd(0, 5, 0, 0); rd(1, 100, 0, 0); rd(2, 7, 0, 0); cyc(0, 0);
    cyc(0, 0);
    chk("rdq_final", rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_port_dram.md
MULTI_PORT_DRAM -- requirements
Module: multi_port_dram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits.
REQ-002 Parameter ADDR_W, default 12, address width per port.
REQ-003 Parameter DEPTH, default 3075, number of words; the legal address range is 0..DEPTH-1.
REQ-004 Parameter NPORTS, default 4, number of independent read/write ports (1..8).
REQ-005 Parameter READ_MODE, default 0: 0 = read-old (read-before-write), 1 = write-first.
REQ-006 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-008 Port data_in, input, NPORTS*DATA_W, write data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-009 Port addr, input, NPORTS*ADDR_W, address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 Port we, input, NPORTS, per-port write enable.
REQ-011 Port re, input, NPORTS, per-port read request.
REQ-012 Port data_out, output, NPORTS*DATA_W, registered read data.
REQ-013 Port rvalid, output, NPORTS, per-port read-data valid.
REQ-014 Port addr_err, output, NPORTS, per-port one-cycle out-of-range pulse.
REQ-015 Port wr_conflict, output, 1, one-cycle pulse when two or more ports write the same address in one cycle.
REQ-016 Port conflict_cnt, output, 16, saturating count of wr_conflict cycles.
REQ-017 Port ready, output, 1, high when the memory accepts port traffic.

Function
REQ-018 Controller states: CLEAR (zero-fill) and RUN; rst_n low forces CLEAR with the fill pointer at 0.
REQ-019 In CLEAR, one word per cycle (pointer 0..DEPTH-1) is written to zero; ready=0; we/re from all ports are ignored; rvalid, addr_err and wr_conflict stay 0.
REQ-020 CLEAR->RUN on the edge that writes word DEPTH-1; ready=1 from the next cycle, i.e. exactly DEPTH cycles after rst_n deasserts.
REQ-021 In RUN, each port with we=1 and a legal address writes data_in to that address on the rising edge.
REQ-022 When several ports write the same legal address in one cycle, the highest-numbered port's data is stored; the write pulses wr_conflict on the following cycle.
REQ-023 In RUN, re=1 registers the read: data_out and rvalid update one cycle later (latency 1); rvalid=0 otherwise, and data_out holds its last value.
REQ-024 On a read from the address being written in the same cycle (by any port), READ_MODE=0 returns the pre-write contents and READ_MODE=1 returns the winning write data per REQ-022.
REQ-025 An address >= DEPTH suppresses that port's write; on a read, data_out returns 0 with rvalid=1. In both cases addr_err pulses for that port one cycle later.
REQ-026 conflict_cnt increments by one per conflict cycle and saturates at 16'hFFFF.
REQ-027 Ports with we=0 and re=0 have no effect; a port may assert we and re together, with the read governed by REQ-024.
REQ-028 Asserting rst_n mid-CLEAR or mid-RUN aborts the current activity and restarts CLEAR from address 0; pending reads produce no rvalid.

Reset
REQ-029 While rst_n=0: data_out=0, rvalid=0, addr_err=0, wr_conflict=0, conflict_cnt=0, ready=0, state=CLEAR, fill pointer=0.
REQ-030 Memory contents are undefined during rst_n=0 and are all zero once ready rises.

Verification
REQ-031 Release reset with we=1 on port 0 during fill -> ready rises exactly DEPTH cycles later; a subsequent read of every address returns 0.
REQ-032 RUN: port1 writes 32'hDEADBEEF @5; next cycle port2 reads @5 -> one cycle later data_out[2]=32'hDEADBEEF, rvalid[2]=1, then rvalid[2]=0.
REQ-033 Ports 0 and 3 write 32'h1 and 32'h3 @100 in the same cycle -> wr_conflict pulses once, conflict_cnt=1, and a read @100 returns 32'h3.
REQ-034 @7 holds 32'hA; port0 writes 32'hB @7 while port1 reads @7 -> data_out[1]=32'hA with READ_MODE=0 and 32'hB with READ_MODE=1.
REQ-035 Port2 writes @DEPTH, then reads @DEPTH -> no memory change; addr_err[2] pulses each time; the read returns 0 with rvalid[2]=1.
REQ-036 rst_n pulsed low at fill pointer 1000 -> ready=0, conflict_cnt=0, and the fill restarts at 0, with ready rising DEPTH cycles after release.
